// File: rtl/rds_carrier_timebase.sv
// 57 kHz RDS subcarrier NCO with subcarrier-cycle, half-bit and bit strobes.
// All outputs are registered; reset > sync > en in priority.
module rds_carrier_timebase #(
    parameter int unsigned ACC_WIDTH      = 32,
    parameter int unsigned FREQ_INC       = 2176117,
    parameter int unsigned PHASE_BITS     = 10,
    parameter int unsigned CYCLES_PER_BIT = 48
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              en,
    input  logic                              sync,
    output logic [PHASE_BITS-1:0]             phase,
    output logic                              carrier_strobe,
    output logic                              half_strobe,
    output logic                              bit_strobe,
    output logic                              bit_half,
    output logic [$clog2(CYCLES_PER_BIT)-1:0] cycle_cnt
);
    localparam int unsigned        CNT_W    = $clog2(CYCLES_PER_BIT);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [CNT_W-1:0]   CNT_MID  = CNT_W'(CYCLES_PER_BIT / 2 - 1);
    localparam logic [ACC_WIDTH:0] INC_EXT  = (ACC_WIDTH + 1)'(FREQ_INC);

    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 half_q, half_d;
    logic                 car_q, car_d;
    logic                 hs_q, hs_d;
    logic                 bs_q, bs_d;
    logic [ACC_WIDTH:0]   sum;
    logic                 wrap;

    // The extra MSB of the widened sum is the carry that marks a subcarrier cycle.
    always_comb begin
        sum  = {1'b0, acc_q} + INC_EXT;
        wrap = sum[ACC_WIDTH];
    end

    always_comb begin
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        half_d = half_q;
        car_d  = 1'b0;
        hs_d   = 1'b0;
        bs_d   = 1'b0;
        if (sync) begin
            acc_d  = '0;
            cnt_d  = '0;
            half_d = 1'b0;
        end else if (en) begin
            acc_d = sum[ACC_WIDTH-1:0];
            car_d = wrap;
            if (wrap) begin
                bs_d = (cnt_q == CNT_LAST);
                hs_d = (cnt_q == CNT_LAST) || (cnt_q == CNT_MID);
                if (cnt_q == CNT_LAST) begin
                    cnt_d  = '0;
                    half_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_MID) begin
                        half_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            half_q <= 1'b0;
            car_q  <= 1'b0;
            hs_q   <= 1'b0;
            bs_q   <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            half_q <= half_d;
            car_q  <= car_d;
            hs_q   <= hs_d;
            bs_q   <= bs_d;
        end
    end

    assign phase          = acc_q[ACC_WIDTH-1 -: PHASE_BITS];
    assign cycle_cnt      = cnt_q;
    assign bit_half       = half_q;
    assign carrier_strobe = car_q;
    assign half_strobe    = hs_q;
    assign bit_strobe     = bs_q;
endmodule

// File: tb/tb_rds_carrier_timebase.sv
// Self-checking bench: a small-parameter and a default-parameter instance driven
// in lockstep, checked against a model built on the count of enabled advances.
module tb_rds_carrier_timebase;
    logic clk = 1'b0;
    logic reset, en, sync;

    logic [1:0] s_phase;
    logic       s_car, s_hs, s_bs, s_half;
    logic [1:0] s_cnt;

    logic [9:0] d_phase;
    logic       d_car, d_hs, d_bs, d_half;
    logic [5:0] d_cnt;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Enabled advances since the last reset/sync for each instance.
    longint unsigned ns = 0;
    longint unsigned nd = 0;
    bit              stepped;

    always #5 clk = ~clk;

    rds_carrier_timebase #(
        .ACC_WIDTH(8), .FREQ_INC(64), .PHASE_BITS(2), .CYCLES_PER_BIT(4)
    ) u_small (
        .clk(clk), .reset(reset), .en(en), .sync(sync),
        .phase(s_phase), .carrier_strobe(s_car), .half_strobe(s_hs),
        .bit_strobe(s_bs), .bit_half(s_half), .cycle_cnt(s_cnt)
    );

    rds_carrier_timebase u_dflt (
        .clk(clk), .reset(reset), .en(en), .sync(sync),
        .phase(d_phase), .carrier_strobe(d_car), .half_strobe(d_hs),
        .bit_strobe(d_bs), .bit_half(d_half), .cycle_cnt(d_cnt)
    );

    task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Outputs follow directly from n: acc = n*inc mod 2^aw, completed cycles = n*inc / 2^aw.
    task automatic ref_outs(input longint unsigned n, input int unsigned aw, input longint unsigned inc,
                            input int unsigned pb, input int unsigned cpb, input bit adv,
                            output longint unsigned ph, output longint unsigned cyc,
                            output bit half, output bit car, output bit hs, output bit bs);
        longint unsigned prod, w, pw;
        prod = n * inc;
        w    = prod >> aw;
        pw   = (adv && n > 0) ? (((n - 1) * inc) >> aw) : w;
        car  = adv && (w != pw);
        cyc  = w % cpb;
        ph   = (prod % (64'd1 << aw)) >> (aw - pb);
        half = (cyc >= cpb / 2);
        bs   = car && (cyc == 0);
        hs   = car && ((cyc % (cpb / 2)) == 0);
    endtask

    task automatic step();
        longint unsigned ph, cyc;
        bit half, car, hs, bs;
        @(posedge clk);
        if (reset || sync) begin
            ns = 0; nd = 0; stepped = 1'b0;
        end else if (en) begin
            ns++; nd++; stepped = 1'b1;
        end else begin
            stepped = 1'b0;
        end
        #1;
        ref_outs(ns, 8, 64, 2, 4, stepped, ph, cyc, half, car, hs, bs);
        check("s_phase", s_phase, ph);
        check("s_cycle_cnt", s_cnt, cyc);
        check("s_bit_half", s_half, half);
        check("s_carrier", s_car, car);
        check("s_half_strobe", s_hs, hs);
        check("s_bit_strobe", s_bs, bs);
        ref_outs(nd, 32, 2176117, 10, 48, stepped, ph, cyc, half, car, hs, bs);
        check("d_phase", d_phase, ph);
        check("d_cycle_cnt", d_cnt, cyc);
        check("d_bit_half", d_half, half);
        check("d_carrier", d_car, car);
        check("d_half_strobe", d_hs, hs);
        check("d_bit_strobe", d_bs, bs);
    endtask

    initial begin
        int unsigned nbs, nhs, k, dcar_got, dcar_exp;
        longint unsigned nd_prev;
        reset = 1'b1; en = 1'b1; sync = 1'b0;
        for (int i = 0; i < 3; i++) step();

        // Free run: two bits' worth of strobes in 32 clocks.
        reset = 1'b0;
        nbs = 0; nhs = 0;
        for (int i = 0; i < 32; i++) begin
            step();
            nbs += s_bs;
            nhs += s_hs;
        end
        check("bit_strobe_count_32", nbs, 2);
        check("half_strobe_count_32", nhs, 4);

        // Stall mid-bit at cycle_cnt=2, phase=3, then resume.
        sync = 1'b1; step(); sync = 1'b0;
        for (int i = 0; i < 11; i++) step();
        check("pre_stall_cnt", s_cnt, 2);
        check("pre_stall_phase", s_phase, 3);
        en = 1'b0;
        for (int i = 0; i < 5; i++) step();
        en = 1'b1;
        for (int i = 0; i < 8; i++) step();

        // Sync on the clock a bit strobe would fire; next bit 16 clocks later.
        k = 0;
        while ((ns % 16) != 15 && k < 64) begin step(); k++; end
        check("align_bound", ((ns % 16) == 15) ? 1 : 0, 1);
        sync = 1'b1; step(); sync = 1'b0;
        check("sync_kills_bit_strobe", s_bs, 0);
        k = 0;
        do begin step(); k++; end while (!s_bs && k < 40);
        check("bit_after_sync_clocks", k, 16);

        // Reset together with sync and en mid-bit, then cold-start behaviour.
        for (int i = 0; i < 6; i++) step();
        reset = 1'b1; sync = 1'b1; step();
        reset = 1'b0; sync = 1'b0;
        for (int i = 0; i < 20; i++) step();

        // Randomised control with occasional sync/reset.
        for (int i = 0; i < 6000; i++) begin
            en    = ($urandom_range(0, 7) != 0);
            sync  = ($urandom_range(0, 63) == 0);
            reset = ($urandom_range(0, 255) == 0);
            step();
        end

        // Long stretch without realignment so the default instance wraps repeatedly.
        reset = 1'b0; sync = 1'b0;
        nd_prev = nd;
        dcar_got = 0;
        for (int i = 0; i < 25000; i++) begin
            en = ($urandom_range(0, 7) != 0);
            step();
            dcar_got += d_car;
        end
        dcar_exp = int'((nd * 64'd2176117 >> 32) - (nd_prev * 64'd2176117 >> 32));
        check("d_carrier_count", dcar_got, dcar_exp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
